// File: rtl/irrigation_sequencer.sv
// Timed Moore sequencer driving the sprinkler pump and dripper valve from a debounced request.
// Enforces settle, max-run, cooldown and fault-clear windows counted in divisor ticks.
module irrigation_sequencer #(
  parameter int SETTLE_TICKS      = 4,
  parameter int RUN_TICKS         = 16,
  parameter int COOLDOWN_TICKS    = 8,
  parameter int FAULT_CLEAR_TICKS = 4,
  parameter int TIMER_WIDTH       = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       irrigation_request,
  input  logic       splinker_select,
  input  logic       low_water_level,
  input  logic       conflicting_values,
  output logic       splinker_bomb,
  output logic       dripper_valvule,
  output logic       alarm_fault,
  output logic       busy,
  output logic [2:0] state_code,
  output logic [3:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    SPRINKLE = 3'd2,
    DRIP     = 3'd3,
    COOLDOWN = 3'd4,
    FAULT    = 3'd5
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] SETTLE_LAST = TIMER_WIDTH'(SETTLE_TICKS - 1);
  localparam logic [TIMER_WIDTH-1:0] RUN_LAST    = TIMER_WIDTH'(RUN_TICKS - 1);
  localparam logic [TIMER_WIDTH-1:0] COOL_LAST   = TIMER_WIDTH'(COOLDOWN_TICKS - 1);
  localparam logic [TIMER_WIDTH-1:0] FAULT_LAST  = TIMER_WIDTH'(FAULT_CLEAR_TICKS - 1);

  state_t                 state, state_next;
  logic [TIMER_WIDTH-1:0] timer, timer_next;
  logic                   mode, mode_next;
  logic                   count_inc;
  logic                   run_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      mode        <= 1'b0;
      cycle_count <= 4'd0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      mode  <= mode_next;
      if (count_inc) cycle_count <= cycle_count + 4'd1;
    end
  end

  assign run_ok = irrigation_request && low_water_level;

  always_comb begin
    state_next = state;
    mode_next  = mode;
    count_inc  = 1'b0;
    timer_next = tick ? timer + TIMER_WIDTH'(1) : timer;
    case (state)
      IDLE: begin
        timer_next = '0;
        if (conflicting_values) begin
          state_next = FAULT;
        end else if (run_ok) begin
          state_next = SETTLE;
          mode_next  = splinker_select;
        end
      end
      SETTLE: begin
        if (conflicting_values)                     state_next = FAULT;
        else if (!run_ok || splinker_select != mode) state_next = IDLE;
        else if (tick && timer == SETTLE_LAST)       state_next = mode ? SPRINKLE : DRIP;
      end
      SPRINKLE, DRIP: begin
        // Mode is frozen here: select changes are deliberately not looked at.
        if (conflicting_values) begin
          state_next = FAULT;
        end else if (!run_ok || (tick && timer == RUN_LAST)) begin
          state_next = COOLDOWN;
          count_inc  = 1'b1;
        end
      end
      COOLDOWN: begin
        if (conflicting_values)               state_next = FAULT;
        else if (tick && timer == COOL_LAST) state_next = IDLE;
      end
      FAULT: begin
        // Only an unbroken run of clean ticks releases the fault.
        if (conflicting_values)               timer_next = '0;
        else if (tick && timer == FAULT_LAST) state_next = COOLDOWN;
      end
      default: state_next = IDLE;
    endcase
    if (state_next != state) timer_next = '0;
  end

  assign splinker_bomb   = (state == SPRINKLE);
  assign dripper_valvule = (state == DRIP);
  assign alarm_fault     = (state == FAULT);
  assign busy            = (state != IDLE);
  assign state_code      = state;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Bench for irrigation_sequencer: vector table, directed corner sequences and random stimulus
// checked against a countdown-based behavioural model.
module tb_irrigation_sequencer;

  localparam int SETTLE_T = 4;
  localparam int RUN_T    = 16;
  localparam int COOL_T   = 8;
  localparam int FCLR_T   = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tick, irrigation_request, splinker_select, low_water_level, conflicting_values;
  logic       splinker_bomb, dripper_valvule, alarm_fault, busy;
  logic [2:0] state_code;
  logic [3:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  int m_state, m_left, m_count;
  bit m_mode;

  irrigation_sequencer #(
    .SETTLE_TICKS(SETTLE_T), .RUN_TICKS(RUN_T), .COOLDOWN_TICKS(COOL_T),
    .FAULT_CLEAR_TICKS(FCLR_T), .TIMER_WIDTH(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .tick(tick),
    .irrigation_request(irrigation_request), .splinker_select(splinker_select),
    .low_water_level(low_water_level), .conflicting_values(conflicting_values),
    .splinker_bomb(splinker_bomb), .dripper_valvule(dripper_valvule),
    .alarm_fault(alarm_fault), .busy(busy), .state_code(state_code),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: each state holds a "ticks remaining" budget.
  function automatic void model_reset();
    m_state = 0; m_left = 0; m_count = 0; m_mode = 1'b0;
  endfunction

  function automatic void m_enter(int s);
    m_state = s;
    case (s)
      1:       m_left = SETTLE_T;
      2, 3:    m_left = RUN_T;
      4:       m_left = COOL_T;
      5:       m_left = FCLR_T;
      default: m_left = 0;
    endcase
  endfunction

  function automatic void model_step(bit rq, bit lw, bit sl, bit cf, bit tk);
    case (m_state)
      0: if (cf) m_enter(5);
         else if (rq && lw) begin m_mode = sl; m_enter(1); end
      1: if (cf) m_enter(5);
         else if (!rq || !lw || sl != m_mode) m_enter(0);
         else if (tk) begin m_left--; if (m_left == 0) m_enter(m_mode ? 2 : 3); end
      2, 3: if (cf) m_enter(5);
         else if (!rq || !lw) begin m_count = (m_count + 1) % 16; m_enter(4); end
         else if (tk) begin
           m_left--;
           if (m_left == 0) begin m_count = (m_count + 1) % 16; m_enter(4); end
         end
      4: if (cf) m_enter(5);
         else if (tk) begin m_left--; if (m_left == 0) m_enter(0); end
      5: if (cf) m_left = FCLR_T;
         else if (tk) begin m_left--; if (m_left == 0) m_enter(4); end
      default: m_enter(0);
    endcase
  endfunction

  task automatic compare_model();
    chk("model_state", 32'(state_code), 32'(m_state));
    chk("model_count", 32'(cycle_count), 32'(m_count));
    chk("model_outs", {28'd0, splinker_bomb, dripper_valvule, alarm_fault, busy},
        {28'd0, m_state == 2, m_state == 3, m_state == 5, m_state != 0});
  endtask

  // Called #1 after a rising edge: drive, take one edge, check.
  task automatic step(input logic rq, input logic lw, input logic sl, input logic cf, input logic tk);
    irrigation_request = rq; low_water_level = lw; splinker_select = sl;
    conflicting_values = cf; tick = tk;
    @(posedge clock);
    model_step(rq, lw, sl, cf, tk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    irrigation_request = 0; low_water_level = 0; splinker_select = 0;
    conflicting_values = 0; tick = 0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic       req, low, sel, conf, tk;
    logic [2:0] st;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[14];
  int n_set, n_spr, n_drp, n_bomb, n_cool, n;
  bit seen;
  logic sel_r;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 4'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 4'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 4'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 4'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 4'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 4'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 4'd0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 4'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 4'd0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 4'd0};

    do_reset();
    chk("reset_state", 32'(state_code), 0);
    chk("reset_count", 32'(cycle_count), 0);
    chk("reset_outs", {28'd0, splinker_bomb, dripper_valvule, alarm_fault, busy}, 0);

    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].low, vecs[i].sel, vecs[i].conf, vecs[i].tk);
      chk($sformatf("vec%0d_state", i), 32'(state_code), 32'(vecs[i].st));
      chk($sformatf("vec%0d_count", i), 32'(cycle_count), 32'(vecs[i].cnt));
    end

    // Full sprinkler run.
    do_reset();
    n_set = 0; n_spr = 0; n_cool = 0; n_drp = 0;
    for (int i = 0; i < 29; i++) begin
      step(1, 1, 1, 0, 1);
      if (state_code == 3'd1) n_set++;
      if (state_code == 3'd2) n_spr++;
      if (state_code == 3'd4) n_cool++;
      if (dripper_valvule) n_drp++;
    end
    chk("spr_settle_clocks", n_set, SETTLE_T);
    chk("spr_run_clocks", n_spr, RUN_T);
    chk("spr_cool_clocks", n_cool, COOL_T);
    chk("spr_drip_clocks", n_drp, 0);
    chk("spr_end_state", 32'(state_code), 0);
    chk("spr_end_count", 32'(cycle_count), 1);

    // Dripper run with select toggled mid-run.
    do_reset();
    n_drp = 0; n_bomb = 0;
    for (int i = 0; i < 29; i++) begin
      sel_r = (n_drp >= 5);
      step(1, 1, sel_r, 0, 1);
      if (dripper_valvule) n_drp++;
      if (splinker_bomb) n_bomb++;
    end
    chk("drip_run_clocks", n_drp, RUN_T);
    chk("drip_bomb_clocks", n_bomb, 0);
    chk("drip_end_count", 32'(cycle_count), 1);

    // Aborts during SETTLE.
    do_reset();
    step(1, 1, 1, 0, 1); step(1, 1, 1, 0, 1);
    step(0, 1, 1, 0, 1);
    chk("abort_req_state", 32'(state_code), 0);
    step(1, 1, 1, 0, 1); step(1, 1, 1, 0, 1);
    step(1, 1, 0, 0, 1);
    chk("abort_sel_state", 32'(state_code), 0);
    chk("abort_count", 32'(cycle_count), 0);

    // Conflict during SPRINKLE, then an interrupted clean window.
    do_reset();
    repeat (SETTLE_T + 3) step(1, 1, 1, 0, 1);
    chk("pre_fault_state", 32'(state_code), 2);
    step(1, 1, 1, 1, 1);
    chk("fault_state", 32'(state_code), 5);
    chk("fault_alarm_bomb", {30'd0, alarm_fault, splinker_bomb}, 2);
    step(1, 1, 1, 0, 1); step(1, 1, 1, 0, 1);
    step(1, 1, 1, 1, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 1, 0, 1);
      n++;
      if (state_code == 3'd4) break;
    end
    chk("fault_clean_ticks", n, FCLR_T);
    chk("fault_count", 32'(cycle_count), 0);

    // Sparse ticks stretch the run.
    do_reset();
    n_spr = 0; seen = 0;
    for (int i = 0; i < 200; i++) begin
      step(1, 1, 1, 0, logic'(i % 3 == 0));
      if (state_code == 3'd2) begin n_spr++; seen = 1; end
      else if (seen) break;
    end
    chk("slow_run_clocks", n_spr, 3 * RUN_T);
    chk("slow_end_state", 32'(state_code), 4);
    chk("slow_count", 32'(cycle_count), 1);

    // Low water mid-run ends it early and counts it.
    do_reset();
    repeat (SETTLE_T + 3) step(1, 1, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    chk("lowwater_state", 32'(state_code), 4);
    chk("lowwater_count", 32'(cycle_count), 1);

    // Asynchronous reset mid-DRIP.
    do_reset();
    repeat (SETTLE_T + 1) step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    repeat (COOL_T) step(0, 1, 0, 0, 1);
    repeat (SETTLE_T + 4) step(1, 1, 0, 0, 1);
    chk("pre_rst_state", 32'(state_code), 3);
    chk("pre_rst_count", 32'(cycle_count), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_outs", {25'd0, dripper_valvule, busy, state_code, cycle_count}, 0);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    step(0, 1, 0, 0, 1);
    chk("post_rst_state", 32'(state_code), 0);

    // Random stimulus against the model.
    do_reset();
    sel_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) sel_r = ~sel_r;
      step(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 15) != 0), sel_r,
           logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
